// File: rtl/keypad_scanner_if.sv
// Keypad-facing and consumer-facing signals of the 4x4 matrix keypad scanner.
// The master side is the scanner; the slave side is the board/keypad plus the logic that consumes key events.
interface keypad_scanner_if;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  row_n,
    output col_n,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output row_n,
    input  col_n,
    input  key_code,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_scanner.sv
// Column-scanning, debouncing decoder for a 4x4 hex keypad.
// Each accepted press produces a one-cycle key_valid strobe carrying its hex code.
module keypad_scanner #(
  parameter int CLK_HZ         = 100_000_000,
  parameter int SCAN_HZ        = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic clk,
  input  logic rst_n,
  keypad_scanner_if.master kp
);

  localparam int         DWELL = CLK_HZ / SCAN_HZ;
  localparam int         DW    = $clog2(DWELL);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [3:0] DEB   = 4'(DEBOUNCE_SCANS);

  localparam logic [1:0] ST_IDLE        = 2'd0;
  localparam logic [1:0] ST_PRESS_CHK   = 2'd1;
  localparam logic [1:0] ST_HELD        = 2'd2;
  localparam logic [1:0] ST_RELEASE_CHK = 2'd3;

  logic [3:0]    row_s1, row_s2;
  logic [DW-1:0] dwell;
  logic [1:0]    col;
  logic [1:0]    acc_cnt;
  logic [3:0]    acc_code;
  logic [2:0]    col_cnt, tot_cnt;
  logic [3:0]    col_code, scan_code;
  logic          sample, scan_end, scan_none, scan_single;
  logic [1:0]    state;
  logic [3:0]    cnt, cnt_inc, cand;
  logic [3:0]    key_code;
  logic          key_valid;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: key_map = 4'h1;  4'h1: key_map = 4'h2;  4'h2: key_map = 4'h3;  4'h3: key_map = 4'hA;
      4'h4: key_map = 4'h4;  4'h5: key_map = 4'h5;  4'h6: key_map = 4'h6;  4'h7: key_map = 4'hB;
      4'h8: key_map = 4'h7;  4'h9: key_map = 4'h8;  4'hA: key_map = 4'h9;  4'hB: key_map = 4'hC;
      4'hC: key_map = 4'h0;  4'hD: key_map = 4'hF;  4'hE: key_map = 4'hE;  default: key_map = 4'hD;
    endcase
  endfunction

  assign sample   = (dwell == DWELL_LAST);
  assign scan_end = sample && (col == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_s1 <= 4'b1111;
      row_s2 <= 4'b1111;
      dwell  <= '0;
      col    <= 2'd0;
    end else begin
      row_s1 <= kp.row_n;
      row_s2 <= row_s1;
      if (sample) begin
        dwell <= '0;
        col   <= col + 2'd1;
      end else begin
        dwell <= dwell + 1'b1;
      end
    end
  end

  // Rows found in the current column are merged with the running scan totals,
  // so the scan-end decision already includes column 3.
  always_comb begin
    col_cnt  = 3'd0;
    col_code = 4'h0;
    for (int r = 0; r < 4; r++) begin
      if (!row_s2[r]) begin
        col_cnt  = col_cnt + 3'd1;
        col_code = key_map(r[1:0], col);
      end
    end
    tot_cnt     = {1'b0, acc_cnt} + col_cnt;
    scan_code   = (col_cnt != 3'd0) ? col_code : acc_code;
    scan_none   = (tot_cnt == 3'd0);
    scan_single = (tot_cnt == 3'd1);
    cnt_inc     = (cnt == 4'hF) ? cnt : cnt + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt  <= 2'd0;
      acc_code <= 4'h0;
    end else if (sample) begin
      if (col == 2'd3) begin
        acc_cnt  <= 2'd0;
        acc_code <= 4'h0;
      end else begin
        acc_cnt  <= (tot_cnt >= 3'd2) ? 2'd2 : tot_cnt[1:0];
        acc_code <= scan_code;
      end
    end
  end

  // Debounce decisions are taken once per full scan; rollover needs a release first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      cand      <= 4'h0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (scan_end) begin
        case (state)
          ST_IDLE: begin
            if (scan_single) begin
              cand <= scan_code;
              cnt  <= 4'd1;
              if (DEBOUNCE_SCANS == 1) begin
                state     <= ST_HELD;
                key_code  <= scan_code;
                key_valid <= 1'b1;
              end else begin
                state <= ST_PRESS_CHK;
              end
            end
          end
          ST_PRESS_CHK: begin
            if (scan_single && scan_code == cand) begin
              cnt <= cnt_inc;
              if (cnt_inc >= DEB) begin
                state     <= ST_HELD;
                key_code  <= cand;
                key_valid <= 1'b1;
              end
            end else if (scan_single) begin
              cand <= scan_code;
              cnt  <= 4'd1;
            end else begin
              state <= ST_IDLE;
              cnt   <= 4'd0;
            end
          end
          ST_HELD: begin
            if (scan_none) begin
              if (DEBOUNCE_SCANS == 1) begin
                state <= ST_IDLE;
                cnt   <= 4'd0;
              end else begin
                state <= ST_RELEASE_CHK;
                cnt   <= 4'd1;
              end
            end
          end
          default: begin
            if (scan_none) begin
              cnt <= cnt_inc;
              if (cnt_inc >= DEB) state <= ST_IDLE;
            end else begin
              state <= ST_HELD;
              cnt   <= 4'd0;
            end
          end
        endcase
      end
    end
  end

  assign kp.col_n     = ~(4'b0001 << col);
  assign kp.key_code  = key_code;
  assign kp.key_valid = key_valid;
  assign kp.key_held  = (state == ST_HELD) || (state == ST_RELEASE_CHK);

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a keypad matrix model (DWELL=10, 40-cycle scans, 3-scan debounce).
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] keys;
  logic [3:0]  rows;
  int          checks = 0;
  int          fails = 0;
  int          strobes = 0;
  logic [3:0]  strobe_code = 4'h0;

  keypad_scanner_if kp();

  keypad_scanner #(
    .CLK_HZ(1000),
    .SCAN_HZ(100),
    .DEBOUNCE_SCANS(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .kp(kp)
  );

  always #5 clk = ~clk;

  // A pressed key (r,c) pulls row r low while column c is driven low.
  always_comb begin
    rows = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !kp.col_n[c]) rows[r] = 1'b0;
  end
  assign kp.row_n = rows;

  always @(negedge clk) begin
    if (kp.key_valid === 1'b1) begin
      strobes++;
      strobe_code = kp.key_code;
    end
  end

  task automatic align_scan();
    int n;
    n = 0;
    while (kp.col_n !== 4'b0111 && n < 100) begin @(negedge clk); n++; end
    while (kp.col_n !== 4'b1110 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      checks++; fails++;
      $display("[TB] FAIL align_scan: col_n=%b, required a 0111->1110 step within 100 cycles", kp.col_n);
    end
  endtask

  task automatic wait_strobe(input int bound, output int n);
    n = 0;
    while (n < bound) begin
      @(negedge clk);
      n++;
      if (kp.key_valid === 1'b1) break;
    end
    #1;
  endtask

  task automatic wait_held_low(input int bound, output int n);
    n = 0;
    while (n < bound) begin
      @(negedge clk);
      n++;
      if (kp.key_held === 1'b0) break;
    end
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] exp_cols [4];
    exp_cols = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    keys  = 16'h0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (kp.col_n !== 4'b1110) begin fails++; $display("[TB] FAIL reset_col: got %b want 1110", kp.col_n); end
    checks++; if (kp.key_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid: got %b want 0", kp.key_valid); end
    checks++; if (kp.key_held !== 1'b0) begin fails++; $display("[TB] FAIL reset_held: got %b want 0", kp.key_held); end
    checks++; if (kp.key_code !== 4'h0) begin fails++; $display("[TB] FAIL reset_code: got %h want 0", kp.key_code); end
    rst_n = 1'b1;
    for (int s = 0; s < 4; s++) begin
      repeat (10) @(negedge clk);
      checks++;
      if (kp.col_n !== exp_cols[s]) begin
        fails++; $display("[TB] FAIL col_step%0d: got %b want %b", s + 1, kp.col_n, exp_cols[s]);
      end
    end
    checks++; if (strobes !== 0) begin fails++; $display("[TB] FAIL reset_no_strobe: got %0d want 0", strobes); end
  endtask

  task automatic test_clean_press();
    int s0, n;
    s0 = strobes;
    align_scan();
    keys[9] = 1'b1;
    wait_strobe(200, n);
    checks++; if (n !== 120) begin fails++; $display("[TB] FAIL press8_latency: got %0d want 120", n); end
    checks++; if (kp.key_code !== 4'h8) begin fails++; $display("[TB] FAIL press8_code: got %h want 8", kp.key_code); end
    checks++; if (kp.key_held !== 1'b1) begin fails++; $display("[TB] FAIL press8_held: got %b want 1", kp.key_held); end
    align_scan();
    keys = 16'h0;
    wait_held_low(200, n);
    checks++; if (n !== 120) begin fails++; $display("[TB] FAIL release8_latency: got %0d want 120", n); end
    checks++; if (strobes !== s0 + 1) begin fails++; $display("[TB] FAIL press8_strobes: got %0d want %0d", strobes - s0, 1); end
  endtask

  task automatic test_bounce();
    int s0, n;
    s0 = strobes;
    align_scan();
    for (int i = 0; i < 6; i++) begin
      keys[3] = (i % 2 == 0);
      repeat (40) @(negedge clk);
    end
    #1;
    checks++; if (strobes !== s0) begin fails++; $display("[TB] FAIL bounce_no_strobe: got %0d want 0", strobes - s0); end
    checks++; if (kp.key_held !== 1'b0) begin fails++; $display("[TB] FAIL bounce_held: got %b want 0", kp.key_held); end
    keys[3] = 1'b1;
    wait_strobe(200, n);
    checks++; if (n !== 120) begin fails++; $display("[TB] FAIL bounceA_latency: got %0d want 120", n); end
    checks++; if (kp.key_code !== 4'hA) begin fails++; $display("[TB] FAIL bounceA_code: got %h want A", kp.key_code); end
    align_scan();
    keys = 16'h0;
    wait_held_low(200, n);
    checks++; if (kp.key_held !== 1'b0) begin fails++; $display("[TB] FAIL bounceA_release: got %b want 0", kp.key_held); end
  endtask

  task automatic test_multi_rollover();
    int s0, n;
    s0 = strobes;
    align_scan();
    keys[12] = 1'b1;
    keys[13] = 1'b1;
    repeat (160) @(negedge clk);
    #1;
    checks++; if (strobes !== s0) begin fails++; $display("[TB] FAIL multi_no_strobe: got %0d want 0", strobes - s0); end
    checks++; if (kp.key_held !== 1'b0) begin fails++; $display("[TB] FAIL multi_held: got %b want 0", kp.key_held); end
    keys[13] = 1'b0;
    wait_strobe(200, n);
    checks++; if (n !== 120) begin fails++; $display("[TB] FAIL key0_latency: got %0d want 120", n); end
    checks++; if (kp.key_code !== 4'h0) begin fails++; $display("[TB] FAIL key0_code: got %h want 0", kp.key_code); end
    keys[5] = 1'b1;
    repeat (160) @(negedge clk);
    #1;
    checks++; if (strobes !== s0 + 1) begin fails++; $display("[TB] FAIL rollover_no_strobe: got %0d want 1", strobes - s0); end
    checks++; if (kp.key_held !== 1'b1) begin fails++; $display("[TB] FAIL rollover_held: got %b want 1", kp.key_held); end
    keys = 16'h0;
    wait_held_low(200, n);
    checks++; if (n !== 120) begin fails++; $display("[TB] FAIL rollover_release: got %0d want 120", n); end
    keys[5] = 1'b1;
    wait_strobe(200, n);
    checks++; if (n !== 120) begin fails++; $display("[TB] FAIL key5_latency: got %0d want 120", n); end
    checks++; if (strobe_code !== 4'h5) begin fails++; $display("[TB] FAIL key5_code: got %h want 5", strobe_code); end
    checks++; if (strobes !== s0 + 2) begin fails++; $display("[TB] FAIL key5_strobes: got %0d want 2", strobes - s0); end
    align_scan();
    keys = 16'h0;
    wait_held_low(200, n);
  endtask

  task automatic test_brief_release();
    int s0, n, low_seen;
    s0 = strobes;
    low_seen = 0;
    align_scan();
    keys[10] = 1'b1;
    wait_strobe(200, n);
    checks++; if (kp.key_code !== 4'h9) begin fails++; $display("[TB] FAIL key9_code: got %h want 9", kp.key_code); end
    keys = 16'h0;
    repeat (40) begin @(negedge clk); if (kp.key_held !== 1'b1) low_seen++; end
    keys[10] = 1'b1;
    repeat (160) begin @(negedge clk); if (kp.key_held !== 1'b1) low_seen++; end
    #1;
    checks++; if (low_seen !== 0) begin fails++; $display("[TB] FAIL brief_held: held low %0d cycles, want 0", low_seen); end
    checks++; if (strobes !== s0 + 1) begin fails++; $display("[TB] FAIL brief_strobes: got %0d want 1", strobes - s0); end
    align_scan();
    keys = 16'h0;
    wait_held_low(200, n);
  endtask

  task automatic test_reset_mid_debounce();
    int s0, n;
    s0 = strobes;
    align_scan();
    keys[0] = 1'b1;
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (kp.key_code !== 4'h0) begin fails++; $display("[TB] FAIL midrst_code: got %h want 0", kp.key_code); end
    checks++; if (kp.key_held !== 1'b0) begin fails++; $display("[TB] FAIL midrst_held: got %b want 0", kp.key_held); end
    checks++; if (kp.col_n !== 4'b1110) begin fails++; $display("[TB] FAIL midrst_col: got %b want 1110", kp.col_n); end
    checks++; if (strobes !== s0) begin fails++; $display("[TB] FAIL midrst_no_strobe: got %0d want 0", strobes - s0); end
    @(negedge clk);
    rst_n = 1'b1;
    wait_strobe(200, n);
    checks++; if (n !== 120) begin fails++; $display("[TB] FAIL midrst_latency: got %0d want 120", n); end
    checks++; if (kp.key_code !== 4'h1) begin fails++; $display("[TB] FAIL midrst_code1: got %h want 1", kp.key_code); end
    keys = 16'h0;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_multi_rollover();
    test_brief_release();
    test_reset_mid_debounce();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
